riscv_core_dcache_axi_rd_adapter: RTL
=====================================

# riscv_core_dcache_axi_rd_adapter

AXI4 read-channel adapter for the data cache refill path. It accepts a single-cycle-sampled refill request and a block address from the dcache controller and issues one AXI4 INCR burst on the AR channel. It collects the R-channel beats into one cache block and returns that block to the dcache memory with a one-cycle done pulse. It sits between the dcache refill interface and the SoC AXI interconnect.

## Interface
- ADDR_WIDTH, 32, byte address width
- BLOCK_WIDTH, 256, cache block width in bits; must equal the dcache refill block width
- BEAT_WIDTH, 64, AXI RDATA width; BLOCK_WIDTH/BEAT_WIDTH is a power of two, 2..16
- AXI_ID, 0, constant ARID value

- i_clk  input  1  clock; all logic is rising-edge
- i_rst  input  1  reset; synchronous, active-high
- i_mem_read_req  input  1  refill request from the dcache controller
- i_mem_read_address  input  ADDR_WIDTH  refill address
- o_mem_read_done  output  1  one-cycle pulse: block valid
- o_block_from_axi  output  BLOCK_WIDTH  assembled block
- o_read_error  output  1  qualifies done: bad RRESP or RLAST error in this burst
- o_arvalid / i_arready  output/input  1  AR handshake
- o_arid  output  4  AXI_ID
- o_araddr  output  ADDR_WIDTH  burst start address
- o_arlen  output  8  BEATS-1
- o_arsize  output  3  log2(BEAT_WIDTH/8)
- o_arburst  output  2  burst type
- i_rvalid / o_rready  input/output  1  R handshake
- i_rdata  input  BEAT_WIDTH  beat data
- i_rresp  input  2  beat response
- i_rlast  input  1  last beat

## Operation
- BEATS = BLOCK_WIDTH/BEAT_WIDTH. The beat counter is log2(BEATS) bits wide.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If i_mem_read_req = 1, capture the address into the AR register and go to ADDR.
  - The captured address has its low log2(BLOCK_WIDTH/8) bits cleared.
  - Clear the beat counter and the error flag.
- ADDR:
  - o_arvalid = 1. araddr, arlen and arsize are driven from registers.
  - Every AR field stays stable until i_arready.
  - On handshake, go to DATA.
- DATA:
  - o_rready = 1.
  - On each i_rvalid & o_rready, write i_rdata into o_block_from_axi[cnt*BEAT_WIDTH +: BEAT_WIDTH], then increment cnt.
  - Set the error flag if i_rresp != 2'b00.
  - Set the error flag if i_rlast does not match (cnt == BEATS-1).
  - On the handshake of beat BEATS-1, go to DONE, regardless of i_rlast.
- DONE:
  - o_mem_read_done = 1 and o_read_error = error flag, both for exactly one cycle.
  - Go to IDLE.
  - i_mem_read_req is ignored in DONE. The controller must drop the request in the cycle it sees done.
- o_block_from_axi:
  - Changes only on R handshakes.
  - Holds its value from done until the next burst's first beat.
- Beats with i_rvalid low: no state change.
- R traffic while in IDLE or ADDR is not accepted, because o_rready = 0.
- o_arburst = 2'b01 (INCR) in the default build.

## Timing
- Reset values:
  - FSM = IDLE.
  - o_arvalid, o_rready, o_mem_read_done, o_read_error = 0.
  - o_araddr = 0, o_block_from_axi = 0, cnt = 0.
  - o_arlen, o_arsize, o_arburst and o_arid are constants.
- Reset during ADDR or DATA aborts to IDLE on the next edge. The interconnect is reset on the same reset.
- Request sampled at cycle 0:
  - o_arvalid is high from cycle 1.
  - With i_arready at cycle 1, o_rready is high from cycle 2.
  - Back-to-back beats handshake at cycles 2..BEATS+1.
  - o_mem_read_done is at cycle BEATS+2, which is 6 for the defaults.
- Minimum request-to-request spacing: a new request is accepted in the IDLE cycle after DONE.
- Every output is registered or decoded from the FSM state only. There is no combinational path from AXI inputs to outputs.

## Configuration
- DCACHE_RD_WRAP_BURST_EN defined (critical-word-first):
  - o_araddr keeps the beat index bits and clears only the log2(BEAT_WIDTH/8) byte bits.
  - o_arburst = 2'b10 (WRAP).
  - cnt initialises to the requested beat index and wraps modulo BEATS.
  - The RLAST check fires on the BEATS-th handshake of the burst, not on cnt == BEATS-1.
  - Placement uses cnt, so the final block is identical to an INCR fill.
- Not defined: INCR burst from the block-aligned address. cnt starts at 0.

## Test plan
- Read request at 0x0000_1234; AR accepted immediately; 4 back-to-back beats 0x11..11, 0x22..22, 0x33..33, 0x44..44; RLAST on beat 3 -> araddr=0x0000_1220, arlen=3, arsize=3, arburst=01. Done at cycle 6 with block = {44..,33..,22..,11..}, error=0.
- i_arready held low for 5 cycles -> arvalid and araddr stay stable for 5 cycles. rready stays low. Done is delayed by 5 cycles.
- i_rvalid toggles 1,0,1,0,… -> the block still assembles correctly. Done occurs 1 cycle after the 4th handshake.
- Beat 1 has RRESP=2'b10 -> all 4 beats are still consumed. Done is asserted with o_read_error=1. The next clean burst has o_read_error=0.
- RLAST asserted on beat 2 -> o_read_error=1 at done. Done occurs after beat 3.
- With DCACHE_RD_WRAP_BURST_EN, request 0x0000_1250 -> araddr=0x0000_1250, arburst=10. Beats arriving in order 2,3,0,1 land in their correct slots. Done at cycle 6.
- i_rst asserted mid-DATA -> all outputs are at reset values after the next edge. A following request completes normally.

Source files
------------

// File: rtl/riscv_core_dcache_axi_rd_adapter_if.sv
// AXI4 read-address and read-data channels between the dcache refill adapter and the interconnect.
interface riscv_core_dcache_axi_rd_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BEAT_WIDTH = 64
);
    logic                  arvalid;
    logic                  arready;
    logic [3:0]            arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [BEAT_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/riscv_core_dcache_axi_rd_adapter.sv
// Dcache refill adapter: one AXI4 read burst per request, beats assembled into one cache block.
// Optional DCACHE_RD_WRAP_BURST_EN selects a critical-word-first WRAP burst instead of INCR.
module riscv_core_dcache_axi_rd_adapter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH  = 64,
    parameter int unsigned AXI_ID      = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]  i_mem_read_address,
    output logic                   o_mem_read_done,
    output logic [BLOCK_WIDTH-1:0] o_block_from_axi,
    output logic                   o_read_error,
    riscv_core_dcache_axi_rd_adapter_if.master axi
);
    localparam int unsigned BEATS      = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam int unsigned BLK_OFF_W  = $clog2(BLOCK_WIDTH / 8);
    localparam int unsigned BEAT_OFF_W = $clog2(BEAT_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                 state_q, state_nxt;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic                   err_q, err_nxt;
    logic [BLOCK_WIDTH-1:0] block_q;
    logic                   arvalid_q, rready_q, done_q, rerr_q;
    logic                   beat_hs;
    logic                   last_beat;

`ifdef DCACHE_RD_WRAP_BURST_EN
    // Handshake count marks the end of a wrapped burst, since cnt starts mid-block.
    logic [CNT_W-1:0] seen_q, seen_nxt;
    logic             unused_addr_bits;
    assign unused_addr_bits = ^i_mem_read_address[BEAT_OFF_W-1:0];
    assign last_beat        = (seen_q == CNT_W'(BEATS - 1));
    assign axi.arburst      = 2'b10;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_mem_read_address[BLK_OFF_W-1:0];
    assign last_beat        = (cnt_q == CNT_W'(BEATS - 1));
    assign axi.arburst      = 2'b01;
`endif

    assign beat_hs = (state_q == DATA) && axi.rvalid;

    assign axi.arid    = 4'(AXI_ID);
    assign axi.arlen   = 8'(BEATS - 1);
    assign axi.arsize  = 3'(BEAT_OFF_W);
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.rready  = rready_q;

    assign o_mem_read_done  = done_q;
    assign o_read_error     = rerr_q;
    assign o_block_from_axi = block_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        araddr_nxt = araddr_q;
        cnt_nxt    = cnt_q;
        err_nxt    = err_q;
`ifdef DCACHE_RD_WRAP_BURST_EN
        seen_nxt   = seen_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                err_nxt = 1'b0;
`ifdef DCACHE_RD_WRAP_BURST_EN
                seen_nxt = '0;
                if (i_mem_read_req) begin
                    araddr_nxt = {i_mem_read_address[ADDR_WIDTH-1:BEAT_OFF_W], BEAT_OFF_W'(0)};
                    cnt_nxt    = i_mem_read_address[BLK_OFF_W-1:BEAT_OFF_W];
                    state_nxt  = ADDR;
                end
`else
                if (i_mem_read_req) begin
                    araddr_nxt = {i_mem_read_address[ADDR_WIDTH-1:BLK_OFF_W], BLK_OFF_W'(0)};
                    state_nxt  = ADDR;
                end
`endif
            end
            ADDR: begin
                if (axi.arready) state_nxt = DATA;
            end
            DATA: begin
                if (beat_hs) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
`ifdef DCACHE_RD_WRAP_BURST_EN
                    seen_nxt = seen_q + CNT_W'(1);
`endif
                    if ((axi.rresp != 2'b00) || (axi.rlast != last_beat)) err_nxt = 1'b1;
                    if (last_beat) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs, decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            araddr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            block_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            rerr_q    <= 1'b0;
`ifdef DCACHE_RD_WRAP_BURST_EN
            seen_q    <= '0;
`endif
        end else begin
            araddr_q  <= araddr_nxt;
            cnt_q     <= cnt_nxt;
            err_q     <= err_nxt;
            arvalid_q <= (state_nxt == ADDR);
            rready_q  <= (state_nxt == DATA);
            done_q    <= (state_nxt == DONE);
            rerr_q    <= (state_nxt == DONE) && err_nxt;
`ifdef DCACHE_RD_WRAP_BURST_EN
            seen_q    <= seen_nxt;
`endif
            if (beat_hs) begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                    if (cnt_q == CNT_W'(b)) block_q[b*BEAT_WIDTH +: BEAT_WIDTH] <= axi.rdata;
                end
            end
        end
    end
endmodule
